// File: rtl/restoration_pkg.sv
// restoration_pkg
//   Shared defaults for the restoration pipeline: fixed-point word width,
//   fractional bits, and the saturation bounds for the default width.
//   Modules built at other widths derive their own bounds from WIDTH.
package restoration_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_FRAC  = 16;

    localparam logic signed [DEF_WIDTH-1:0] SAT_MAX = {1'b0, {(DEF_WIDTH-1){1'b1}}};
    localparam logic signed [DEF_WIDTH-1:0] SAT_MIN = {1'b1, {(DEF_WIDTH-1){1'b0}}};

endpackage

// File: rtl/restoration_pipe_fx_mul.sv
// fx_mul
//   Signed fixed-point multiply: full 2*WIDTH product, arithmetic shift
//   right by FRAC (round toward -inf), saturate back to WIDTH.
// Ports:
//   x, y : WIDTH-bit two's-complement operands
//   p    : saturated WIDTH-bit result
//   sat  : 1 when the shifted product did not fit and p was clamped
module fx_mul
    import restoration_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC
) (
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] p,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic signed [2*WIDTH-1:0] full;
    logic signed [2*WIDTH-1:0] shifted;
    logic        [WIDTH:0]     hi;

    always_comb begin
        full    = $signed(x) * $signed(y);
        shifted = full >>> FRAC;
        // Result fits only if every bit from the WIDTH-1 sign position up
        // is a copy of the sign.
        hi      = shifted[2*WIDTH-1:WIDTH-1];
        sat     = !((&hi) || !(|hi));
        if (sat) begin
            p = shifted[2*WIDTH-1] ? MIN : MAX;
        end else begin
            p = shifted[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/restoration_pipe.sv
// restoration_pipe
//   Three-stage Izhikevich recovery-variable update.
//     restoration: post_u = u + h*(a*(b*v - u))
//     spike      : post_u = u + d
//   All multiplies and adds saturate; out_sat flags any clamp in the beat
//   (in spike mode only the u+d add contributes).
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   in_valid/in_ready          : input handshake
//   in_ch, in_spike            : channel tag, mode select
//   v, u, a, b, h, d           : WIDTH-bit Q(WIDTH-FRAC).FRAC operands
//   out_valid/out_ready        : output handshake
//   out_ch, post_u, out_sat    : result tag, value, saturation flag
//   sat_sticky, sat_clr        : sticky saturation flag and its clear
module restoration_pipe
    import restoration_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = DEF_FRAC,
    parameter int N_CH  = 4,
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CH_W-1:0]  in_ch,
    input  logic             in_spike,
    input  logic [WIDTH-1:0] v,
    input  logic [WIDTH-1:0] u,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] h,
    input  logic [WIDTH-1:0] d,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CH_W-1:0]  out_ch,
    output logic [WIDTH-1:0] post_u,
    output logic             out_sat,
    output logic             sat_sticky,
    input  logic             sat_clr
);

    localparam logic [WIDTH-1:0] MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

    // Returns {sat, result} of x+y (sub=0) or x-y (sub=1), clamped to WIDTH.
    function automatic logic [WIDTH:0] sat_add(input logic [WIDTH-1:0] x,
                                               input logic [WIDTH-1:0] y,
                                               input logic             sub);
        logic [WIDTH:0] s;
        if (sub) s = {x[WIDTH-1], x} - {y[WIDTH-1], y};
        else     s = {x[WIDTH-1], x} + {y[WIDTH-1], y};
        if (s[WIDTH] != s[WIDTH-1]) return {1'b1, (s[WIDTH] ? MIN : MAX)};
        return {1'b0, s[WIDTH-1:0]};
    endfunction

    logic advance;
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Stage 1 registers
    logic             s1_valid, s1_spike, s1_sat;
    logic [CH_W-1:0]  s1_ch;
    logic [WIDTH-1:0] s1_diff, s1_u, s1_d, s1_a, s1_h;
    // Stage 2 registers
    logic             s2_valid, s2_spike, s2_sat;
    logic [CH_W-1:0]  s2_ch;
    logic [WIDTH-1:0] s2_t, s2_u, s2_d, s2_h;

    logic [WIDTH-1:0] bv, t, ht, diff, sum;
    logic             bv_sat, t_sat, ht_sat, sub_sat, add_sat, res_sat;

    fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_bv (.x(b),    .y(v),       .p(bv), .sat(bv_sat));
    fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_t  (.x(s1_a), .y(s1_diff), .p(t),  .sat(t_sat));
    fx_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul_ht (.x(s2_h), .y(s2_t),    .p(ht), .sat(ht_sat));

    always_comb begin
        {sub_sat, diff} = sat_add(bv, u, 1'b1);
        {add_sat, sum}  = sat_add(s2_u, (s2_spike ? s2_d : ht), 1'b0);
        res_sat         = s2_spike ? add_sat : (s2_sat | ht_sat | add_sat);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0; s1_spike <= 1'b0; s1_sat <= 1'b0; s1_ch <= '0;
            s1_diff  <= '0;   s1_u     <= '0;   s1_d   <= '0;   s1_a  <= '0; s1_h <= '0;
            s2_valid <= 1'b0; s2_spike <= 1'b0; s2_sat <= 1'b0; s2_ch <= '0;
            s2_t     <= '0;   s2_u     <= '0;   s2_d   <= '0;   s2_h  <= '0;
            out_valid <= 1'b0; out_sat <= 1'b0; out_ch <= '0; post_u <= '0;
        end else if (advance) begin
            // Data registers load only behind a valid beat, so bubbles
            // leave the previous contents (including the outputs) intact.
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_diff  <= diff;
                s1_sat   <= bv_sat | sub_sat;
                s1_u     <= u;
                s1_d     <= d;
                s1_a     <= a;
                s1_h     <= h;
                s1_ch    <= in_ch;
                s1_spike <= in_spike;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_t     <= t;
                s2_sat   <= s1_sat | t_sat;
                s2_u     <= s1_u;
                s2_d     <= s1_d;
                s2_h     <= s1_h;
                s2_ch    <= s1_ch;
                s2_spike <= s1_spike;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                post_u  <= sum;
                out_sat <= res_sat;
                out_ch  <= s2_ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_sticky <= 1'b0;
        end else if (out_valid && out_ready && out_sat) begin
            sat_sticky <= 1'b1;
        end else if (sat_clr) begin
            sat_sticky <= 1'b0;
        end
    end

endmodule

// File: tb/tb_restoration_pipe.sv
// tb_restoration_pipe
//   Directed and random stimulus for restoration_pipe (Q16.16, 8 channels).
//   Expected results come from a 64-bit saturating reference model, are
//   queued on acceptance and compared in order when the DUT transfers.
module tb_restoration_pipe;
    import restoration_pkg::*;

    logic        clk, rst_n;
    logic        in_valid, in_ready, in_spike;
    logic [2:0]  in_ch, out_ch;
    logic [31:0] v, u, a, b, h, d, post_u;
    logic        out_valid, out_ready, out_sat, sat_sticky, sat_clr;

    restoration_pipe #(.WIDTH(32), .FRAC(16), .N_CH(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_ch(in_ch), .in_spike(in_spike),
        .v(v), .u(u), .a(a), .b(b), .h(h), .d(d),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
        .post_u(post_u), .out_sat(out_sat), .sat_sticky(sat_sticky), .sat_clr(sat_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  ch;
        logic [31:0] post;
        logic        sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    bit   rnd    = 1'b0;

    localparam longint LMAX = 64'sd2147483647;
    localparam longint LMIN = -64'sd2147483648;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [32:0] m_clamp(input longint x);
        if (x > LMAX) return {1'b1, SAT_MAX};
        if (x < LMIN) return {1'b1, SAT_MIN};
        return {1'b0, x[31:0]};
    endfunction

    function automatic logic [32:0] m_mul(input logic [31:0] x, input logic [31:0] y);
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        p = p >>> 16;
        return m_clamp(p);
    endfunction

    function automatic logic [32:0] m_add(input logic [31:0] x, input logic [31:0] y);
        return m_clamp(longint'($signed(x)) + longint'($signed(y)));
    endfunction

    function automatic logic [32:0] m_sub(input logic [31:0] x, input logic [31:0] y);
        return m_clamp(longint'($signed(x)) - longint'($signed(y)));
    endfunction

    function automatic logic [32:0] model(input bit sp, input logic [31:0] vv, uu, aa, bb, hh, dd);
        logic [32:0] bv, df, t, ht, r;
        if (sp) return m_add(uu, dd);
        bv = m_mul(bb, vv);
        df = m_sub(bv[31:0], uu);
        t  = m_mul(aa, df[31:0]);
        ht = m_mul(hh, t[31:0]);
        r  = m_add(uu, ht[31:0]);
        return {bv[32] | df[32] | t[32] | ht[32] | r[32], r[31:0]};
    endfunction

    // ---------------- driver ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int c, input bit sp,
                        input logic [31:0] vv, uu, aa, bb, hh, dd);
        logic [32:0] r;
        exp_t        e;
        int          n;
        in_valid = 1'b1; in_ch = c[2:0]; in_spike = sp;
        v = vv; u = uu; a = aa; b = bb; h = hh; d = dd;
        n = 0;
        forever begin
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (in_ready) begin
                r = model(sp, vv, uu, aa, bb, hh, dd);
                e.ch = c[2:0]; e.post = r[31:0]; e.sat = r[32];
                sb.push_back(e);
                break;
            end
            n++;
            if (n > 200) begin
                check("accept_timeout", 64'(n), 64'(0));
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while (!(sb.size() == 0 && !out_valid)) begin
            @(posedge clk); #1;
            n++;
            if (n > 100) begin
                check("drain_timeout", 64'(sb.size()), 64'(0));
                sb.delete();
                break;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            n_out++;
            if (sb.size() == 0) begin
                check("unexpected_output", {61'd0, out_ch}, 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                check("out_ch",  64'(out_ch),  64'(e.ch));
                check("post_u",  64'(post_u),  64'(e.post));
                check("out_sat", 64'(out_sat), 64'(e.sat));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        rst_n = 1'b0; in_valid = 1'b0; in_ch = '0; in_spike = 1'b0;
        v = '0; u = '0; a = '0; b = '0; h = '0; d = '0;
        out_ready = 1'b1; sat_clr = 1'b0;

        // Reset state
        #3;
        check("rst_out_valid",  64'(out_valid),  64'(0));
        check("rst_post_u",     64'(post_u),     64'(0));
        check("rst_out_ch",     64'(out_ch),     64'(0));
        check("rst_out_sat",    64'(out_sat),    64'(0));
        check("rst_sat_sticky", 64'(sat_sticky), 64'(0));
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_after_rst", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Restoration basic + latency
        send(1, 1'b0, 32'h0001_0000, 32'h0, 32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0);
        idle();
        check("lat_ov_cycle1", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("lat_ov_cycle2", 64'(out_valid), 64'(0));
        @(posedge clk); #1;
        check("lat_ov_cycle3", 64'(out_valid), 64'(1));
        check("basic_post_u",  64'(post_u),    64'h4000);
        drain();

        // Spike mode, then bubble must leave outputs untouched
        send(2, 1'b1, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0008_0000);
        idle();
        drain();
        repeat (3) @(posedge clk); #1;
        check("bubble_post_u",  64'(post_u),    64'h0009_0000);
        check("bubble_out_ch",  64'(out_ch),    64'(2));
        check("sticky_clean",   64'(sat_sticky), 64'(0));

        // Saturation chain and sticky flag
        send(3, 1'b0, 32'h7FFF_0000, 32'hFFFF_0000, 32'h0001_0000, 32'h0002_0000,
             32'h0001_0000, 32'h0);
        idle();
        drain();
        check("sat_post_u",     64'(post_u),     64'h7FFE_FFFF);
        check("sticky_set",     64'(sat_sticky), 64'(1));
        sat_clr = 1'b1;
        @(posedge clk); #1;
        sat_clr = 1'b0;
        check("sticky_cleared", 64'(sat_sticky), 64'(0));

        // Backpressure: only three beats fit, outputs hold while stalled
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++)
            send(i, 1'b1, 32'h0, 32'(i) << 16, 32'h0, 32'h0, 32'h0, 32'h0001_0000);
        in_valid = 1'b1; in_ch = 3'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready",  64'(in_ready),  64'(0));
            check("stall_accepted",  64'(sb.size()), 64'(3));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_post_u",    64'(post_u),    64'(sb[0].post));
            check("stall_out_ch",    64'(out_ch),    64'(sb[0].ch));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3, 1'b1, 32'h0, 32'h0003_0000, 32'h0, 32'h0, 32'h0, 32'h0001_0000);
        send(4, 1'b1, 32'h0, 32'h0004_0000, 32'h0, 32'h0, 32'h0, 32'h0001_0000);
        idle();
        drain();

        // Random back-to-back beats with random backpressure
        rnd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            send(int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 32'($signed($urandom) >>> $urandom_range(0, 16)),
                 32'($signed($urandom) >>> $urandom_range(4, 16)),
                 32'($signed($urandom) >>> $urandom_range(8, 16)),
                 32'($signed($urandom) >>> $urandom_range(8, 16)),
                 32'($signed($urandom) >>> $urandom_range(8, 16)),
                 32'($signed($urandom) >>> $urandom_range(0, 16)));
        end
        rnd = 1'b0;
        idle();
        drain();

        // Reset with beats in flight
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++)
            send(i + 5, 1'b1, 32'h0, 32'h0001_0000, 32'h0, 32'h0, 32'h0, 32'h0001_0000);
        idle();
        rst_n = 1'b0;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_post_u",    64'(post_u),    64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        base = n_out;
        @(negedge clk);
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(n_out - base), 64'(0));
        check("midrst_sb_empty", 64'(sb.size()),    64'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
